// File: rtl/mod5_pkg.sv
// Shared definitions for mod-5 count stream producers and receivers.
package mod5_pkg;

   localparam int unsigned MOD5_N = 5;
   localparam int unsigned MOD5_W = 3;

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   function automatic logic [MOD5_W-1:0] mod5_inc(input logic [MOD5_W-1:0] v);
      return (v == MOD5_W'(MOD5_N - 1)) ? '0 : MOD5_W'(v + MOD5_W'(1));
   endfunction

endpackage

// File: rtl/mod5_match.sv
// Combinational compare of a received mod-5 value against the expected value.
module mod5_match
   import mod5_pkg::*;
(
   input  logic [MOD5_W-1:0] q_in,
   input  logic [MOD5_W-1:0] expected,
   output logic              legal,
   output logic              hit
);

   always_comb begin
      legal = (q_in < MOD5_W'(MOD5_N));
      hit   = (q_in == expected);
   end

endmodule

// File: rtl/mod_5_seq_checker.sv
// Lock/flywheel checker for the 0..4 mod-5 count stream.
// Optional saturating error counter is built only with MOD5_CHK_ERRCNT_EN defined.
module mod_5_seq_checker
   import mod5_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned LOSS_CNT = 2,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       q_in,
   input  logic             q_valid,
   output logic             locked,
   output logic             err,
   output logic [2:0]       expected,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned MW = $clog2(LOCK_CNT + 1);
   localparam int unsigned LW = $clog2(LOSS_CNT + 1);

   state_t            state, state_nx;
   // exp_q holds ref+1 directly, so no separate ref register is needed
   logic [MOD5_W-1:0] exp_q, exp_nx;
   logic [MW-1:0]     match_q, match_nx;
   logic [LW-1:0]     miss_q, miss_nx;
   logic              err_q, err_nx;
   logic              legal, hit;

   mod5_match u_match (
      .q_in     (q_in),
      .expected (exp_q),
      .legal    (legal),
      .hit      (hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HUNT;
         exp_q   <= '0;
         match_q <= '0;
         miss_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         exp_q   <= exp_nx;
         match_q <= match_nx;
         miss_q  <= miss_nx;
         err_q   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      exp_nx   = exp_q;
      match_nx = match_q;
      miss_nx  = miss_q;
      err_nx   = 1'b0;
      if (q_valid) begin
         unique case (state)
            HUNT: begin
               if (legal) begin
                  state_nx = SYNC;
                  exp_nx   = mod5_inc(q_in);
                  match_nx = MW'(1);
               end
            end
            SYNC: begin
               if (!legal) begin
                  state_nx = HUNT;
                  exp_nx   = '0;
                  match_nx = '0;
               end else if (hit) begin
                  exp_nx   = mod5_inc(exp_q);
                  match_nx = match_q + MW'(1);
                  if (match_q == MW'(LOCK_CNT - 1)) begin
                     state_nx = LOCKED;
                     miss_nx  = '0;
                  end
               end else begin
                  exp_nx   = mod5_inc(q_in);
                  match_nx = MW'(1);
               end
            end
            LOCKED: begin
               // flywheel: advance from our own expectation, never from q_in
               exp_nx = mod5_inc(exp_q);
               if (hit) begin
                  miss_nx = '0;
               end else begin
                  err_nx = 1'b1;
                  if (miss_q == LW'(LOSS_CNT - 1)) begin
                     state_nx = HUNT;
                     exp_nx   = '0;
                     match_nx = '0;
                     miss_nx  = '0;
                  end else begin
                     miss_nx = miss_q + LW'(1);
                  end
               end
            end
            default: begin
               state_nx = HUNT;
               exp_nx   = '0;
               match_nx = '0;
               miss_nx  = '0;
            end
         endcase
      end
   end

   always_comb begin
      locked   = (state == LOCKED);
      err      = err_q;
      expected = exp_q;
   end

`ifdef MOD5_CHK_ERRCNT_EN
   logic [ERR_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (err_nx && (cnt_q != '1)) begin
         cnt_q <= cnt_q + ERR_W'(1);
      end
   end

   assign err_cnt = cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_mod_5_seq_checker.sv
// Directed self-checking bench for mod_5_seq_checker (ERR_W=2 to reach saturation).
module tb_mod_5_seq_checker;

`ifdef MOD5_CHK_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] q_in = '0;
   logic       q_valid = 1'b0;
   logic       locked, err;
   logic [2:0] expected;
   logic [1:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int nerr   = 0;

   mod_5_seq_checker #(
      .LOCK_CNT (3),
      .LOSS_CNT (2),
      .ERR_W    (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .q_in     (q_in),
      .q_valid  (q_valid),
      .locked   (locked),
      .err      (err),
      .expected (expected),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] cnt_exp(input int n);
      if (!CNT_EN) return 8'd0;
      return (n > 3) ? 8'd3 : 8'(n);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic lk, input logic er,
                          input logic [2:0] ex, input int n);
      chk({tag, ".locked"},   {7'd0, locked},  {7'd0, lk});
      chk({tag, ".err"},      {7'd0, err},     {7'd0, er});
      chk({tag, ".expected"}, {5'd0, expected}, {5'd0, ex});
      chk({tag, ".err_cnt"},  {6'd0, err_cnt}, cnt_exp(n));
   endtask

   task automatic step(input logic [2:0] v, input logic vld);
      @(negedge clk);
      q_in    = v;
      q_valid = vld;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_all("por", 1'b0, 1'b0, 3'd0, 0);
      @(negedge clk);
      rst = 1'b0;

      // clean lock and 4->0 wrap
      step(3'd0, 1'b1); chk_all("lk0", 1'b0, 1'b0, 3'd1, nerr);
      step(3'd1, 1'b1); chk_all("lk1", 1'b0, 1'b0, 3'd2, nerr);
      step(3'd2, 1'b1); chk_all("lk2", 1'b1, 1'b0, 3'd3, nerr);
      step(3'd3, 1'b1); chk_all("lk3", 1'b1, 1'b0, 3'd4, nerr);
      step(3'd4, 1'b1); chk_all("lk4", 1'b1, 1'b0, 3'd0, nerr);
      step(3'd0, 1'b1); chk_all("lk5", 1'b1, 1'b0, 3'd1, nerr);
      step(3'd1, 1'b1); chk_all("lk6", 1'b1, 1'b0, 3'd2, nerr);

      // single glitch: flywheel keeps counting, next correct value matches
      step(3'd0, 1'b1); nerr++; chk_all("gl0", 1'b1, 1'b1, 3'd3, nerr);
      step(3'd3, 1'b1);         chk_all("gl1", 1'b1, 1'b0, 3'd4, nerr);

      // valid gaps hold everything
      step(3'd1, 1'b0); chk_all("gap1", 1'b1, 1'b0, 3'd4, nerr);
      for (int i = 0; i < 4; i++) begin
         step(3'd7, 1'b0); chk_all("gap4", 1'b1, 1'b0, 3'd4, nerr);
      end
      step(3'd4, 1'b1); chk_all("gapend", 1'b1, 1'b0, 3'd0, nerr);

      // loss of lock on second consecutive mismatch (legal then illegal)
      step(3'd1, 1'b1); nerr++; chk_all("loss0", 1'b1, 1'b1, 3'd1, nerr);
      step(3'd7, 1'b1); nerr++; chk_all("loss1", 1'b0, 1'b1, 3'd0, nerr);
      step(3'd0, 1'b0);         chk_all("loss2", 1'b0, 1'b0, 3'd0, nerr);

      // relock keeps err_cnt
      step(3'd2, 1'b1); chk_all("rl0", 1'b0, 1'b0, 3'd3, nerr);
      step(3'd3, 1'b1); chk_all("rl1", 1'b0, 1'b0, 3'd4, nerr);
      step(3'd4, 1'b1); chk_all("rl2", 1'b1, 1'b0, 3'd0, nerr);

      // asynchronous reset mid-operation, checked before any clock edge
      #2;
      rst = 1'b1;
      #1;
      nerr = 0;
      chk_all("arst", 1'b0, 1'b0, 3'd0, nerr);
      @(negedge clk);
      rst = 1'b0;

      // first sample after reset enters SYNC; illegal in SYNC returns to HUNT
      step(3'd3, 1'b1); chk_all("sy0", 1'b0, 1'b0, 3'd4, nerr);
      step(3'd4, 1'b1); chk_all("sy1", 1'b0, 1'b0, 3'd0, nerr);
      step(3'd6, 1'b1); chk_all("sy2", 1'b0, 1'b0, 3'd0, nerr);
      step(3'd6, 1'b1); chk_all("hu0", 1'b0, 1'b0, 3'd0, nerr);
      step(3'd1, 1'b1); chk_all("hu1", 1'b0, 1'b0, 3'd2, nerr);
      // legal mismatch in SYNC restarts the match count
      step(3'd0, 1'b1); chk_all("sy3", 1'b0, 1'b0, 3'd1, nerr);
      step(3'd1, 1'b1); chk_all("sy4", 1'b0, 1'b0, 3'd2, nerr);
      step(3'd2, 1'b1); chk_all("sy5", 1'b1, 1'b0, 3'd3, nerr);

      // saturation: five isolated mismatches with good samples between
      step(3'd0, 1'b1); nerr++; chk_all("sat1", 1'b1, 1'b1, 3'd4, nerr);
      step(3'd4, 1'b1);         chk_all("ok1",  1'b1, 1'b0, 3'd0, nerr);
      step(3'd2, 1'b1); nerr++; chk_all("sat2", 1'b1, 1'b1, 3'd1, nerr);
      step(3'd1, 1'b1);         chk_all("ok2",  1'b1, 1'b0, 3'd2, nerr);
      step(3'd5, 1'b1); nerr++; chk_all("sat3", 1'b1, 1'b1, 3'd3, nerr);
      step(3'd3, 1'b1);         chk_all("ok3",  1'b1, 1'b0, 3'd4, nerr);
      step(3'd0, 1'b1); nerr++; chk_all("sat4", 1'b1, 1'b1, 3'd0, nerr);
      step(3'd0, 1'b1);         chk_all("ok4",  1'b1, 1'b0, 3'd1, nerr);
      step(3'd3, 1'b1); nerr++; chk_all("sat5", 1'b1, 1'b1, 3'd2, nerr);
      step(3'd2, 1'b1);         chk_all("ok5",  1'b1, 1'b0, 3'd3, nerr);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_5_seq_checker.md
# mod_5_seq_checker

Receive-side checker for the 3-bit mod-5 count stream (0,1,2,3,4,0,…) produced by the mod-5 counter FSM. It samples the stream on qualified cycles, hunts for and locks onto the sequence, then flywheels an expected value, flagging and counting every deviation. It sits downstream of the counter as an in-design monitor, and is synthesizable.

## Interface
Parameters:
- LOCK_CNT, 3: consecutive in-sequence samples needed to declare lock (≥2).
- LOSS_CNT, 2: consecutive mismatches while locked that drop lock (≥1).
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- q_in  in  3  count value under check.
- q_valid  in  1  q_in is sampled only when high.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per mismatch while locked.
- expected  out  3  value required on the next valid sample; 0 in HUNT.
- err_cnt  out  ERR_W  saturating mismatch count.

## Operation
- Legal values are 0–4. Values 5–7 are illegal. The successor of v is (v+1) mod 5, so 4 is followed by 0.
- When q_valid=0, all state holds and err=0.
- States and transitions:
  - HUNT:
    - Legal sample: ref←q_in, match←1, go to SYNC.
    - Illegal sample: stay in HUNT.
    - err is never raised in HUNT.
  - SYNC:
    - Sample equals expected: match+1. When match reaches LOCK_CNT, go to LOCKED with miss←0.
    - Legal mismatch: ref←q_in, match←1, stay in SYNC.
    - Illegal sample: go to HUNT.
    - err is never raised in SYNC.
  - LOCKED:
    - Match: miss←0.
    - Mismatch (legal or illegal): err pulse, err_cnt+1 (saturates at all-ones), miss+1. Expected advances by flywheel from its own previous value, not from q_in.
    - When miss reaches LOSS_CNT: go to HUNT, locked←0.
- If the mismatch that hits LOSS_CNT is also the one that increments the counter: err=1 and locked=0 on the same edge.
- err_cnt clears only on reset. It is not cleared on loss of lock or on relock.

## Timing
- All outputs are registered and update on the clock edge that samples q_in. There is no extra latency.
- locked rises on the edge that takes the LOCK_CNT-th consecutive matching sample.
- err is high for exactly the cycle after the offending edge.
- expected updates on every valid sample: it becomes ref+1 in SYNC/LOCKED and 0 in HUNT.
- Reset values: state=HUNT, locked=0, err=0, expected=0, err_cnt=0, match=0, miss=0.
- Asserting rst mid-operation forces these values immediately, independent of clk.
- On rst release, the first valid sample is treated as a HUNT sample.

## Configuration
- MOD5_CHK_ERRCNT_EN defined: err_cnt is implemented as described.
- MOD5_CHK_ERRCNT_EN undefined: no counter registers are built and err_cnt is tied to 0.
- In both cases the port list is unchanged, and err, locked and expected behave identically.

## Structure
- Shared package mod5_pkg holds:
  - MOD5_N=5
  - MOD5_W=3
  - state typedef {HUNT, SYNC, LOCKED}
  - function mod5_inc(v) returning (v==4)?0:v+1
- One sub-module, mod5_match: combinational, takes q_in and expected, outputs legal and hit. It is shared with future mod-5 receivers.
- The top holds the FSM, ref/match/miss registers, and the error counter.

## Test plan
- Reset: drive rst=1 while locked with err_cnt=3. Immediately: locked=0, err=0, expected=0, err_cnt=0. After release, the first valid sample enters SYNC.
- Clean lock and wrap: valid every cycle with 0,1,2,3,4,0,1. locked=1 on the edge sampling 2. expected shows 3,4,0,1,2 on the following edges. err is never high. The 4→0 wrap is accepted.
- Single glitch: while locked, expect 1 but drive 3, then drive 2. err is high for one cycle, err_cnt=1, locked stays 1, and the 2 is accepted as a match.
- Loss and relock (LOSS_CNT=2): drive two consecutive mismatches. locked drops on the edge of the second, with err pulsed twice and err_cnt=2. Then drive 3 good samples: locked=1 again and err_cnt stays 2.
- Illegal value and gaps: in SYNC, drive 6 → return to HUNT with no err. Put q_valid=0 gaps of 1–4 cycles inside a locked stream → no state change and no err.
- Saturation (ERR_W=2, macro defined): drive 5 isolated mismatches, each separated by good samples. err_cnt goes 1,2,3,3,3. Rebuild without the macro → err_cnt stays 0.
